// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t         : FSM state encoding (IDLE, RUN, DONE)
//   W_MIN / W_MAX   : legal operand width range
//   cnt_width()     : bit-counter width for a given operand width
package serial_add_pkg;

    localparam int W_MIN = 2;
    localparam int W_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the serial adder.
//   master : drives start, sub, clr, a, b; observes busy, done, sum, cout, ovf
//   slave  : the adder side (directions reversed)
interface serial_add_ctrl_if #(
    parameter int W = 4
);
    logic         start;
    logic         sub;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, clr, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, clr, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/fulladder.sv
// 1-bit full adder cell.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one operand bit per clk cycle, LSB
// first, through a single full-adder cell.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of serial_add_ctrl_if (start/sub/clr/a/b in,
//            busy/done/sum/cout/ovf out, all outputs registered)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one bit per cycle through the cell, busy=1
// DONE  | result just published, done=1 for this cycle; start accepted
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    serial_add_ctrl_if.slave   bus
);

    localparam int CW = cnt_width(W);
    localparam int RW = W - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [RW-1:0] res;      // low W-1 result bits; the MSB comes straight from the cell
    logic          busy_r;
    logic          done_r;
    logic [W-1:0]  sum_r;
    logic          cout_r;
    logic          ovf_r;

    logic fa_s;
    logic fa_co;

    fulladder u_fa (
        .a  (op_a[cnt]),
        .b  (op_b[cnt]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (bus.clr) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry.
                        op_a   <= bus.a;
                        op_b   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry <= fa_co;
                    res   <= RW'({fa_s, res} >> 1);
                    if (cnt == CNT_LAST) begin
                        sum_r  <= {fa_s, res};
                        cout_r <= fa_co;
                        ovf_r  <= carry ^ fa_co;   // carry into MSB vs carry out
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic clk;
    logic resetn;
    int   total;
    int   bad;
    logic seen_done;

    serial_add_ctrl_if #(.W(4)) bus ();

    serial_add_ctrl #(.W(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 16'(bus.busy), 16'd0);
        chk({tag, "_done"}, 16'(bus.done), 16'd0);
        chk({tag, "_sum"},  16'(bus.sum),  16'd0);
        chk({tag, "_cout"}, 16'(bus.cout), 16'd0);
        chk({tag, "_ovf"},  16'(bus.ovf),  16'd0);
    endtask

    // Launch one operation and check the 5-edge start-to-done timing.
    task automatic do_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input logic sv, input logic [3:0] es, input logic ec, input logic eo);
        bus.a = av; bus.b = bv; bus.sub = sv; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy_e0"}, 16'(bus.busy), 16'd1);
        chk({tag, "_done_e0"}, 16'(bus.done), 16'd0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk({tag, "_busy_run"}, 16'(bus.busy), 16'd1);
            chk({tag, "_done_run"}, 16'(bus.done), 16'd0);
        end
        @(posedge clk); #1;
        chk({tag, "_done"}, 16'(bus.done), 16'd1);
        chk({tag, "_busy"}, 16'(bus.busy), 16'd0);
        chk({tag, "_sum"},  16'(bus.sum),  16'(es));
        chk({tag, "_cout"}, 16'(bus.cout), 16'(ec));
        chk({tag, "_ovf"},  16'(bus.ovf),  16'(eo));
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, 16'(bus.done), 16'd0);
        chk({tag, "_sum_hold"},  16'(bus.sum),  16'(es));
    endtask

    initial begin
        total = 0; bad = 0; seen_done = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.clr = 1'b0; bus.a = '0; bus.b = '0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1 chk_zero("reset_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_zero("reset_held");

        // First start sampled on the first edge after release.
        @(negedge clk);
        resetn = 1'b1;
        do_op("add_7_9", 4'd7, 4'd9, 1'b0, 4'd0, 1'b1, 1'b0);
        do_op("sub_3_5", 4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 1'b0);
        do_op("sub_5_3", 4'd5, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);
        do_op("add_7_1", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
        do_op("sub_8_1", 4'd8, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1);

        // start held high: operands changed during RUN must be ignored.
        bus.a = 4'd1; bus.b = 4'd2; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        chk("b2b1_busy_e0", 16'(bus.busy), 16'd1);
        bus.a = 4'd6; bus.b = 4'd6; bus.sub = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk("b2b1_busy_run", 16'(bus.busy), 16'd1);
        end
        @(posedge clk); #1;
        chk("b2b1_done", 16'(bus.done), 16'd1);
        chk("b2b1_sum",  16'(bus.sum),  16'd3);
        chk("b2b1_cout", 16'(bus.cout), 16'd0);
        bus.a = 4'd2; bus.b = 4'd3; bus.sub = 1'b1;
        @(posedge clk); #1;
        chk("b2b2_busy_e0", 16'(bus.busy), 16'd1);
        chk("b2b2_done_e0", 16'(bus.done), 16'd0);
        chk("b2b2_sum_hold", 16'(bus.sum), 16'd3);
        bus.a = 4'd9; bus.b = 4'd4; bus.sub = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk("b2b2_busy_run", 16'(bus.busy), 16'd1);
        end
        @(posedge clk); #1;
        chk("b2b2_done", 16'(bus.done), 16'd1);
        chk("b2b2_sum",  16'(bus.sum),  16'd15);
        chk("b2b2_cout", 16'(bus.cout), 16'd0);
        chk("b2b2_ovf",  16'(bus.ovf),  16'd0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle_busy", 16'(bus.busy), 16'd0);
        chk("b2b_idle_done", 16'(bus.done), 16'd0);

        // Reset two cycles into RUN: outputs clear at once, no done afterwards.
        bus.a = 4'd7; bus.b = 4'd9; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 resetn = 1'b0;
        #1 chk_zero("midrun_reset");
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        chk("midrun_no_done", 16'(seen_done), 16'd0);
        chk("midrun_busy", 16'(bus.busy), 16'd0);

        // clr during RUN, with a simultaneous start that must be ignored.
        do_op("pre_clr", 4'd5, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);
        bus.a = 4'd7; bus.b = 4'd1; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.clr = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        chk_zero("clr_run");
        bus.clr = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        chk("clr_start_ignored", 16'(bus.busy), 16'd0);
        do_op("post_clr", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning operand/result width in bits (legal 2..16).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request one add/subtract operation.
REQ-005 The block SHALL have port sub  input  1  0 = A+B, 1 = A-B, sampled with start.
REQ-006 The block SHALL have port clr  input  1  synchronous abort, priority over start.
REQ-007 The block SHALL have port a  input  W  operand A, sampled with start.
REQ-008 The block SHALL have port b  input  W  operand B, sampled with start.
REQ-009 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 The block SHALL have port sum  output  W  result, held until next accepted start or clr.
REQ-012 The block SHALL have port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-013 The block SHALL have port ovf  output  1  two's-complement overflow of the result.

Function
REQ-014 The block SHALL compute the result bit-serially, LSB first, through exactly one 1-bit full-adder cell, one bit per clk cycle.
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE/DONE + start=1 + clr=0: latch A, latch B (bitwise inverted if sub=1), carry <= sub, bit counter <= 0, go to RUN.
REQ-017 RUN: each cycle feed A[cnt], B[cnt], carry to the cell; shift sum bit into result register; carry <= cell carry; cnt <= cnt+1.
REQ-018 RUN: on the cycle processing bit W-1, capture carry-in of that bit for ovf, then go to DONE.
REQ-019 DONE: done=1 for exactly that cycle; without start, go to IDLE next cycle; with start, accept per REQ-016.
REQ-020 Latency: start sampled at edge 0 -> busy=1 from edge 0 through edge W, done=1 in cycle after edge W (W+1 edges start-to-done).
REQ-021 busy SHALL be 1 exactly in RUN; start in RUN SHALL be ignored without affecting the operation.
REQ-022 sum/cout/ovf SHALL update only on the RUN->DONE transition; internal partial results never visible on sum.
REQ-023 ovf SHALL equal (carry into MSB) XOR (carry out of MSB).
REQ-024 Arithmetic SHALL be modulo 2^W; cout is the (W+1)th bit.
REQ-025 clr=1 in any state: go to IDLE, busy=0, done=0, sum=0, cout=0, ovf=0 next edge; start same cycle ignored.
REQ-026 The bit counter SHALL be ceil(log2(W)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-027 resetn=0 SHALL asynchronously force state IDLE, counter 0, carry 0, operand/result registers 0, busy=0, done=0, sum=0, cout=0, ovf=0.
REQ-028 resetn asserted mid-RUN SHALL abandon the operation; no done pulse after deassertion.
REQ-029 The first accepted start SHALL be the one sampled on the first rising edge after resetn deassertion.

Structure
REQ-030 FSM state encoding (IDLE, RUN, DONE) and width limits SHALL live in shared package serial_add_pkg.
REQ-031 The 1-bit cell SHALL be the team's existing fulladder module, instantiated once; no other sub-modules.
REQ-032 All registers SHALL be in the clk domain; outputs driven directly from registers.

Verification (W=4)
REQ-033 a=7, b=9, sub=0, start pulse -> done after 5 edges, sum=0, cout=1, ovf=0.
REQ-034 a=3, b=5, sub=1 -> sum=14, cout=0, ovf=0; a=5, b=3, sub=1 -> sum=2, cout=1, ovf=0.
REQ-035 a=7, b=1, sub=0 -> sum=8, cout=0, ovf=1; a=8, b=1, sub=1 -> sum=7, cout=1, ovf=1.
REQ-036 start held high continuously with changing a/b -> operations back-to-back, each using operands sampled at IDLE/DONE acceptance, RUN-time start ignored.
REQ-037 resetn pulsed low 2 cycles into RUN -> all outputs 0 immediately, no done; clr in RUN -> IDLE next edge, outputs 0, new start then completes correctly.
